three_to_eight_stream_decoder: RTL and testbench
================================================

THREE_TO_EIGHT_STREAM_DECODER -- requirements
Module: three_to_eight_stream_decoder

Interface
REQ-001 Ports SHALL be, clock and reset first: clk  input  1  single clock for all state.
REQ-002 rst  input  1  reset, asynchronous and active-high.
REQ-003 in_valid  input  1  producer offers in_code this cycle.
REQ-004 in_code  input  3  binary code to decode.
REQ-005 in_ready  output  1  block can accept a code this cycle.
REQ-006 out_valid  output  1  out_onehot holds a decoded word.
REQ-007 out_onehot  output  8  decoded one-hot word.
REQ-008 out_ready  input  1  consumer takes out_onehot this cycle.
REQ-009 level  output  3  number of codes queued in the FIFO (0..4), excluding the output register.
REQ-010 ovf  output  1  sticky flag: a code was offered while in_ready was low.
REQ-011 clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-012 Mapping SHALL be out_onehot = 8'b1000_0000 >> code: 000->8'h80, 001->8'h40, 010->8'h20, 011->8'h10, 100->8'h08, 101->8'h04, 110->8'h02, 111->8'h01.
REQ-013 Exactly one bit of out_onehot SHALL be set while out_valid=1; out_onehot SHALL be 8'h00 while out_valid=0.
REQ-014 The input queue SHALL be a 4-entry FIFO of 3-bit codes with wrap-around read/write pointers.
REQ-015 in_ready SHALL be (level < 4), combinational from registered state only, with no dependence on out_ready.
REQ-016 A push SHALL occur on a rising clk edge when in_valid=1 and in_ready=1.
REQ-017 The output register SHALL load the FIFO head, decoded, on an edge where level>0 and (out_valid=0 or out_ready=1); that entry is popped on the same edge.
REQ-018 A handshake SHALL complete on an edge where out_valid=1 and out_ready=1; if no load occurs on that edge, out_valid SHALL go to 0.
REQ-019 Latency: a code pushed into an empty FIFO with out_valid=0 at edge N SHALL appear with out_valid=1 after edge N+1.
REQ-020 Throughput SHALL be one code per cycle sustained when out_ready is held high.
REQ-021 A simultaneous push and pop SHALL leave level unchanged and order preserved.
REQ-022 When full (level=4), in_valid=1 SHALL NOT push even if a pop occurs on the same edge; the code is dropped and ovf SHALL be set.
REQ-023 While out_valid=1 and out_ready=0, out_onehot and out_valid SHALL hold stable.
REQ-024 Codes SHALL leave in strict arrival order; none SHALL be duplicated or dropped except under REQ-022.
REQ-025 clr_ovf=1 SHALL clear ovf on the next edge; if a new overflow occurs on that same edge, ovf SHALL remain 1.

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, force: level=0, pointers=0, out_valid=0, out_onehot=8'h00, ovf=0, and in_ready=1.
REQ-027 Reset mid-operation SHALL discard all queued and output-register contents; no discarded code SHALL appear after reset is released.
REQ-028 The first push SHALL be accepted on the first rising edge after rst falls.

Verification
REQ-029 Full mapping sweep: codes 0..7 pushed back-to-back with out_ready=1 -> out_onehot 80,40,20,10,08,04,02,01 on consecutive cycles, each one cycle after its push.
REQ-030 Backpressure fill: out_ready=0, push 3,5,7,1,6 -> first code 3 goes to the output register (out_onehot=8'h10), codes 5,7,1,6 fill level to 4, in_ready=0, ovf=0; one further push of 2 -> ovf=1 and code 2 is dropped; then out_ready=1 -> drains 10,04,01,40,02.
REQ-031 Simultaneous push/pop at level=2 with out_ready=1 -> level stays 2, output order is intact.
REQ-032 Async reset: with level=3 and out_valid=1, assert rst between edges -> out_valid, level and ovf read 0 before the next edge; after release, push 4 -> out_onehot=8'h08.
REQ-033 ovf clear race: clr_ovf=1 on the same edge as an overflow -> ovf stays 1; clr_ovf=1 alone on the next edge -> ovf=0.

Source files
------------

// File: rtl/three_to_eight_stream_decoder_if.sv
// Stream bundle for the 3-to-8 decoder: code input stream, one-hot output
// stream, and the FIFO status / overflow control signals.
interface three_to_eight_stream_decoder_if;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_onehot;
    logic       out_ready;
    logic [2:0] level;
    logic       ovf;
    logic       clr_ovf;

    // Driving side: producer of codes and consumer of one-hot words.
    modport master (
        output in_valid, in_code, out_ready, clr_ovf,
        input  in_ready, out_valid, out_onehot, level, ovf
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_code, out_ready, clr_ovf,
        output in_ready, out_valid, out_onehot, level, ovf
    );
endinterface

// File: rtl/three_to_eight_stream_decoder.sv
// 3-to-8 stream decoder: a 4-entry code FIFO feeding a registered one-hot
// output stage. in_ready is taken from the FIFO fill level alone, so a pop on
// the same edge never lets a full FIFO accept a new code.
module three_to_eight_stream_decoder (
    input  logic                                clk,
    input  logic                                rst,
    three_to_eight_stream_decoder_if.slave      bus
);
    localparam int DEPTH = 4;

    logic [2:0] mem [DEPTH];
    logic [1:0] wptr, rptr;
    logic [2:0] count;
    logic       out_valid_r;
    logic [7:0] out_onehot_r;
    logic       ovf_r;
    logic       push, pop;

    assign bus.in_ready   = (count < 3'(DEPTH));
    assign bus.level      = count;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_onehot = out_onehot_r;
    assign bus.ovf        = ovf_r;

    // Push only when there is room; the output stage pulls the head whenever
    // it is empty or its current word is being taken.
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (count != 3'd0) && (!out_valid_r || bus.out_ready);

    // Code storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.in_code;
    end

    // FIFO pointers (2-bit, wrap naturally) and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 2'd1;
            if (pop)  rptr <= rptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Output register: load decoded head on pop, otherwise empty it after a
    // completed handshake; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_onehot_r <= 8'h00;
        end else if (pop) begin
            out_valid_r  <= 1'b1;
            out_onehot_r <= 8'h80 >> mem[rptr];
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r  <= 1'b0;
            out_onehot_r <= 8'h00;
        end
    end

    // Sticky overflow: a new drop wins over a clear on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              ovf_r <= 1'b0;
        else if (bus.in_valid && !bus.in_ready) ovf_r <= 1'b1;
        else if (bus.clr_ovf)                 ovf_r <= 1'b0;
    end
endmodule

// File: tb/tb_three_to_eight_stream_decoder.sv
// Scoreboard bench for the 3-to-8 stream decoder: the driver queues the
// hand-computed one-hot word for every accepted code, and a negedge monitor
// checks each output handshake against the queue in order.
module tb_three_to_eight_stream_decoder;
    logic clk, rst;
    three_to_eight_stream_decoder_if bus();

    three_to_eight_stream_decoder dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] sb[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] code, input logic [7:0] exp);
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        sb.push_back(exp);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            fails++;
            tests++;
            $display("FAIL drain_timeout: %0d words left, expected 0", sb.size());
            sb.delete();
        end
        tick();
        chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("drain_level", {29'd0, bus.level}, 32'd0);
    endtask

    // Monitor: compare each handshake, check idle zero, and stall stability.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_oh   = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("stall_onehot", {24'd0, bus.out_onehot}, {24'd0, prev_oh});
            end
            if (!bus.out_valid)
                chk("idle_onehot", {24'd0, bus.out_onehot}, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h expected none", bus.out_onehot);
                end else begin
                    chk("sb_onehot", {24'd0, bus.out_onehot}, {24'd0, sb.pop_front()});
                end
            end
            prev_hold <= bus.out_valid && !bus.out_ready;
            prev_oh   <= bus.out_onehot;
        end
    end

    logic [7:0] sweep [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_code   = 3'd0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        #2;
        // Reset state, before any clock edge.
        chk("rst_level", {29'd0, bus.level}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_onehot", {24'd0, bus.out_onehot}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (2) tick();
        rst = 1'b0;

        // Full mapping sweep, back-to-back, first push on first edge after reset.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_code  = 3'(i);
            sb.push_back(sweep[i]);
            tick();
            chk("sweep_level", {29'd0, bus.level}, 32'd1);
            if (i == 0) chk("sweep_lat0_valid", {31'd0, bus.out_valid}, 32'd0);
            else        chk("sweep_prev_onehot", {24'd0, bus.out_onehot}, {24'd0, sweep[i-1]});
        end
        bus.in_valid = 1'b0;
        drain();

        // Backpressure fill then overflow drop of code 2.
        bus.out_ready = 1'b0;
        push(3'd3, 8'h10);
        push(3'd5, 8'h04);
        push(3'd7, 8'h01);
        push(3'd1, 8'h40);
        push(3'd6, 8'h02);
        chk("bp_level", {29'd0, bus.level}, 32'd4);
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("bp_onehot", {24'd0, bus.out_onehot}, 32'h10);
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd2;
        tick();
        bus.in_valid = 1'b0;
        chk("bp_ovf_set", {31'd0, bus.ovf}, 32'd1);
        chk("bp_level_full", {29'd0, bus.level}, 32'd4);
        drain();

        // Clear leftover ovf, then clear/overflow race with a pop on a full FIFO.
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("clr_ovf_alone0", {31'd0, bus.ovf}, 32'd0);
        bus.out_ready = 1'b0;
        push(3'd0, 8'h80);
        push(3'd2, 8'h20);
        push(3'd4, 8'h08);
        push(3'd6, 8'h02);
        push(3'd7, 8'h01);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_code   = 3'd1;
        bus.clr_ovf   = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("race_ovf_held", {31'd0, bus.ovf}, 32'd1);
        chk("race_level_pop_no_push", {29'd0, bus.level}, 32'd3);
        tick();
        bus.clr_ovf = 1'b0;
        chk("race_ovf_cleared", {31'd0, bus.ovf}, 32'd0);
        drain();

        // Simultaneous push/pop at level 2.
        bus.out_ready = 1'b0;
        push(3'd1, 8'h40);
        push(3'd3, 8'h10);
        push(3'd5, 8'h04);
        chk("pp_level_pre", {29'd0, bus.level}, 32'd2);
        bus.out_ready = 1'b1;
        push(3'd7, 8'h01);
        chk("pp_level_a", {29'd0, bus.level}, 32'd2);
        push(3'd0, 8'h80);
        chk("pp_level_b", {29'd0, bus.level}, 32'd2);
        drain();

        // Async reset mid-operation with level=3, out_valid=1, ovf=1.
        bus.out_ready = 1'b0;
        push(3'd2, 8'h20);
        push(3'd3, 8'h10);
        push(3'd4, 8'h08);
        push(3'd5, 8'h04);
        push(3'd6, 8'h02);
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd7;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("ar_pre_level", {29'd0, bus.level}, 32'd3);
        chk("ar_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("ar_pre_ovf", {31'd0, bus.ovf}, 32'd1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("ar_level", {29'd0, bus.level}, 32'd0);
        chk("ar_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("ar_onehot", {24'd0, bus.out_onehot}, 32'd0);
        chk("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        push(3'd4, 8'h08);
        chk("ar_post_level", {29'd0, bus.level}, 32'd1);
        tick();
        chk("ar_post_onehot", {24'd0, bus.out_onehot}, 32'h08);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
